// File: rtl/score_counter_if.sv
// score_counter_if: bundle between game logic / renderer and score_counter.
//   master : game-side driver (v_sync_i, hit_i, hit_value_i, clear_i in;
//            score/status and debug observation out)
//   slave  : score_counter itself
// Signals:
//   v_sync_i      vertical sync, low = blanking
//   hit_i         one-cycle pulse, adds hit_value_i points (0 = no-op)
//   hit_value_i   4-bit point value for this hit
//   clear_i       one-cycle pulse, new game
//   score_o       published BCD score {hundreds,tens,units}
//   score_digit_o significant-digit count of the published score
//   busy_o        points still waiting to be applied
//   sat_o         working score has reached 999
//   dbg_inc       FSM state (1 = INC, 0 = IDLE)
//   dbg_pending   pending-points counter
//   dbg_working   working (unpublished) BCD score
// Handshake: there is no valid/ready flow control. hit_i and clear_i are
// single-cycle strobes sampled on every rising clock edge and always accepted;
// a hit that arrives while the score is saturated, or in the same cycle as
// clear_i, is discarded rather than back-pressured.
interface score_counter_if #(
  parameter int PEND_WIDTH = 8
);
  logic                  v_sync_i;
  logic                  hit_i;
  logic [3:0]            hit_value_i;
  logic                  clear_i;
  logic [11:0]           score_o;
  logic [1:0]            score_digit_o;
  logic                  busy_o;
  logic                  sat_o;
  logic                  dbg_inc;
  logic [PEND_WIDTH-1:0] dbg_pending;
  logic [11:0]           dbg_working;

  modport master (
    output v_sync_i, hit_i, hit_value_i, clear_i,
    input  score_o, score_digit_o, busy_o, sat_o,
    input  dbg_inc, dbg_pending, dbg_working
  );

  modport slave (
    input  v_sync_i, hit_i, hit_value_i, clear_i,
    output score_o, score_digit_o, busy_o, sat_o,
    output dbg_inc, dbg_pending, dbg_working
  );
endinterface

// File: rtl/score_counter.sv
// score_counter: accumulates hit points into a 3-digit BCD score (000-999),
// applying one BCD increment per cycle, and publishes the score to the
// renderer only on vertical-blank entry (v_sync_i falling edge).
// Ports:
//   clk_vga  pixel/system clock, all logic on rising edge
//   rst      synchronous active-high reset
//   bus      score_counter_if slave modport (inputs, score/status, debug)
// Parameters:
//   PEND_WIDTH    width of the saturating pending-points counter
//   SYNC_TO_VBLK  1: publish on vblank entry; 0: publish every cycle
module score_counter #(
  parameter int PEND_WIDTH   = 8,
  parameter bit SYNC_TO_VBLK = 1'b1
) (
  input  logic            clk_vga,
  input  logic            rst,
  score_counter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    INC  = 1'b1
  } state_t;

  localparam logic [PEND_WIDTH:0]   PEND_MAX = {1'b0, {PEND_WIDTH{1'b1}}};
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = {{(PEND_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [PEND_WIDTH-1:0] pending_q, pending_d;
  logic [11:0]           working_q, working_d;
  logic [11:0]           score_q, score_d;
  logic [1:0]            digit_q, digit_d;
  logic                  busy_q, busy_d;
  logic                  sat_q, sat_d;
  logic                  v_sync_q, v_sync_d;

  logic [3:0]            add_pts;
  logic                  dec;
  logic                  reach_max;
  logic                  vblk_edge;
  logic [PEND_WIDTH:0]   pend_sum;

  // BCD +1 with ripple carry across all three digits in one cycle. The
  // hundreds digit never wraps; the FSM stops incrementing at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] w);
    logic [3:0] u, t, h;
    u = w[3:0];
    t = w[7:4];
    h = w[11:8];
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        if (h != 4'd9) h = h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {h, t, u};
  endfunction

  function automatic logic [1:0] digits(input logic [11:0] w);
    if (w[11:8] != 4'd0)     return 2'b11;
    else if (w[7:4] != 4'd0) return 2'b10;
    else if (w[3:0] != 4'd0) return 2'b01;
    else                     return 2'b00;
  endfunction

  always_comb begin
    add_pts   = bus.hit_i ? bus.hit_value_i : 4'd0;
    // pending is never zero while in INC; the guard keeps the subtract safe.
    dec       = (state_q == INC) && (pending_q != '0);
    // The increment that turns 998 into 999 also saturates the score.
    reach_max = (state_q == INC) && (working_q == 12'h998);
    vblk_edge = v_sync_q & ~bus.v_sync_i;
    pend_sum  = {1'b0, pending_q}
              + {{(PEND_WIDTH-3){1'b0}}, add_pts}
              - {{PEND_WIDTH{1'b0}}, dec};

    state_d   = state_q;
    pending_d = pending_q;
    working_d = working_q;
    score_d   = score_q;
    digit_d   = digit_q;
    sat_d     = sat_q;
    v_sync_d  = bus.v_sync_i;

    if (bus.clear_i) begin
      state_d   = IDLE;
      pending_d = '0;
      working_d = 12'h000;
      sat_d     = 1'b0;
      score_d   = 12'h000;
      digit_d   = 2'b00;
    end else begin
      if (state_q == INC) working_d = bcd_inc(working_q);
      sat_d = sat_q | reach_max;

      // Once saturated, any remaining or newly arriving points are dropped.
      if (sat_q || reach_max)        pending_d = '0;
      else if (pend_sum > PEND_MAX)  pending_d = '1;
      else                           pending_d = pend_sum[PEND_WIDTH-1:0];

      if (state_q == IDLE) begin
        if ((pending_q != '0) && !sat_q) state_d = INC;
      end else begin
        // Leaving on the last point only if nothing new arrives this cycle.
        if (reach_max || ((pending_q == PEND_ONE) && (add_pts == 4'd0)))
          state_d = IDLE;
      end

      // working_q (not working_d) is published, so an increment landing on
      // the vblank edge shows up one frame later.
      if (!SYNC_TO_VBLK || vblk_edge) begin
        score_d = working_q;
        digit_d = digits(working_q);
      end
    end

    busy_d = (pending_d != '0) || (state_d == INC);
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      working_q <= 12'h000;
      score_q   <= 12'h000;
      digit_q   <= 2'b00;
      busy_q    <= 1'b0;
      sat_q     <= 1'b0;
      v_sync_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      working_q <= working_d;
      score_q   <= score_d;
      digit_q   <= digit_d;
      busy_q    <= busy_d;
      sat_q     <= sat_d;
      v_sync_q  <= v_sync_d;
    end
  end

  assign bus.score_o       = score_q;
  assign bus.score_digit_o = digit_q;
  assign bus.busy_o        = busy_q;
  assign bus.sat_o         = sat_q;
  assign bus.dbg_inc       = (state_q == INC);
  assign bus.dbg_pending   = pending_q;
  assign bus.dbg_working   = working_q;

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed testbench for score_counter (PEND_WIDTH=8,
// SYNC_TO_VBLK=1). Inputs are driven and outputs sampled 1 time unit after
// each rising edge.
module tb_score_counter;

  localparam int BOUND = 2000;

  logic clk_vga;
  logic rst;
  int   checks;
  int   passed;

  score_counter_if #(.PEND_WIDTH(8)) bus ();

  score_counter #(.PEND_WIDTH(8), .SYNC_TO_VBLK(1'b1)) dut (
    .clk_vga (clk_vga),
    .rst     (rst),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_vga = 1'b0;
    forever #5 clk_vga = ~clk_vga;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic do_hit(input logic [3:0] v);
    bus.hit_i       = 1'b1;
    bus.hit_value_i = v;
    tick();
    bus.hit_i       = 1'b0;
    bus.hit_value_i = 4'd0;
  endtask

  task automatic do_clear();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
  endtask

  task automatic publish();
    bus.v_sync_i = 1'b0;
    tick();
    bus.v_sync_i = 1'b1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy_o && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  task automatic add_points(input int total);
    int rem;
    int n;
    rem = total;
    while (rem > 0) begin
      do_hit((rem > 15) ? 4'd15 : 4'(rem));
      rem = (rem > 15) ? rem - 15 : 0;
      wait_idle(n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.v_sync_i = 1'b1;
    bus.hit_i = 1'b1;
    bus.hit_value_i = 4'd9;
    bus.clear_i = 1'b0;
    tick();
    tick();
    bus.hit_i = 1'b0;
    bus.hit_value_i = 4'd0;
    rst = 1'b0;
    checks++; if (bus.score_o !== 12'h000) $display("FAIL rst_score got %h exp 000", bus.score_o); else passed++;
    checks++; if (bus.score_digit_o !== 2'b00) $display("FAIL rst_digit got %b exp 00", bus.score_digit_o); else passed++;
    checks++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy_o); else passed++;
    checks++; if (bus.sat_o !== 1'b0) $display("FAIL rst_sat got %b exp 0", bus.sat_o); else passed++;
    checks++; if (bus.dbg_pending !== 8'd0) $display("FAIL rst_pending got %0d exp 0", bus.dbg_pending); else passed++;
    checks++; if (bus.dbg_working !== 12'h000) $display("FAIL rst_working got %h exp 000", bus.dbg_working); else passed++;
    checks++; if (bus.dbg_inc !== 1'b0) $display("FAIL rst_state got %b exp 0", bus.dbg_inc); else passed++;
  endtask

  task automatic test_hit5();
    int n;
    do_hit(4'd5);
    checks++; if (bus.dbg_pending !== 8'd5) $display("FAIL h5_pending got %0d exp 5", bus.dbg_pending); else passed++;
    wait_idle(n);
    checks++; if (n !== 6) $display("FAIL h5_cycles got %0d exp 6", n); else passed++;
    checks++; if (bus.dbg_working !== 12'h005) $display("FAIL h5_working got %h exp 005", bus.dbg_working); else passed++;
    checks++; if (bus.score_o !== 12'h000) $display("FAIL h5_hold got %h exp 000", bus.score_o); else passed++;
    publish();
    checks++; if (bus.score_o !== 12'h005) $display("FAIL h5_pub got %h exp 005", bus.score_o); else passed++;
    checks++; if (bus.score_digit_o !== 2'b01) $display("FAIL h5_digit got %b exp 01", bus.score_digit_o); else passed++;
    checks++; if (bus.busy_o !== 1'b0) $display("FAIL h5_busy got %b exp 0", bus.busy_o); else passed++;
  endtask

  task automatic test_carry();
    int n;
    do_hit(4'd4);
    wait_idle(n);
    do_hit(4'd1);
    wait_idle(n);
    checks++; if (bus.score_o !== 12'h005) $display("FAIL cy_hold got %h exp 005", bus.score_o); else passed++;
    publish();
    checks++; if (bus.score_o !== 12'h010) $display("FAIL cy_010 got %h exp 010", bus.score_o); else passed++;
    checks++; if (bus.score_digit_o !== 2'b10) $display("FAIL cy_010_digit got %b exp 10", bus.score_digit_o); else passed++;
    // 89 more points as back-to-back hits: 5x15 + 14
    bus.hit_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.hit_value_i = (i < 5) ? 4'd15 : 4'd14;
      tick();
    end
    bus.hit_i = 1'b0;
    bus.hit_value_i = 4'd0;
    wait_idle(n);
    publish();
    checks++; if (bus.score_o !== 12'h099) $display("FAIL cy_099 got %h exp 099", bus.score_o); else passed++;
    checks++; if (bus.score_digit_o !== 2'b10) $display("FAIL cy_099_digit got %b exp 10", bus.score_digit_o); else passed++;
    do_hit(4'd1);
    wait_idle(n);
    publish();
    checks++; if (bus.score_o !== 12'h100) $display("FAIL cy_100 got %h exp 100", bus.score_o); else passed++;
    checks++; if (bus.score_digit_o !== 2'b11) $display("FAIL cy_100_digit got %b exp 11", bus.score_digit_o); else passed++;
  endtask

  task automatic test_sat();
    int n;
    add_points(895);
    checks++; if (bus.dbg_working !== 12'h995) $display("FAIL sat_pre got %h exp 995", bus.dbg_working); else passed++;
    checks++; if (bus.sat_o !== 1'b0) $display("FAIL sat_pre_flag got %b exp 0", bus.sat_o); else passed++;
    do_hit(4'd9);
    wait_idle(n);
    checks++; if (n !== 5) $display("FAIL sat_cycles got %0d exp 5", n); else passed++;
    checks++; if (bus.dbg_working !== 12'h999) $display("FAIL sat_working got %h exp 999", bus.dbg_working); else passed++;
    checks++; if (bus.sat_o !== 1'b1) $display("FAIL sat_flag got %b exp 1", bus.sat_o); else passed++;
    checks++; if (bus.dbg_pending !== 8'd0) $display("FAIL sat_pending got %0d exp 0", bus.dbg_pending); else passed++;
    do_hit(4'd3);
    checks++; if (bus.dbg_pending !== 8'd0) $display("FAIL sat_ignore_pend got %0d exp 0", bus.dbg_pending); else passed++;
    checks++; if (bus.busy_o !== 1'b0) $display("FAIL sat_ignore_busy got %b exp 0", bus.busy_o); else passed++;
    tick();
    tick();
    checks++; if (bus.dbg_working !== 12'h999) $display("FAIL sat_hold got %h exp 999", bus.dbg_working); else passed++;
    publish();
    checks++; if (bus.score_o !== 12'h999) $display("FAIL sat_pub got %h exp 999", bus.score_o); else passed++;
    checks++; if (bus.score_digit_o !== 2'b11) $display("FAIL sat_digit got %b exp 11", bus.score_digit_o); else passed++;
  endtask

  task automatic test_pend_sat();
    int n;
    do_clear();
    checks++; if (bus.sat_o !== 1'b0) $display("FAIL ps_clr_sat got %b exp 0", bus.sat_o); else passed++;
    checks++; if (bus.dbg_working !== 12'h000) $display("FAIL ps_clr_working got %h exp 000", bus.dbg_working); else passed++;
    bus.hit_i = 1'b1;
    bus.hit_value_i = 4'd15;
    for (int i = 0; i < 17; i++) tick();
    checks++; if (bus.dbg_pending !== 8'd240) $display("FAIL ps_240 got %0d exp 240", bus.dbg_pending); else passed++;
    bus.hit_value_i = 4'd11;
    tick();
    checks++; if (bus.dbg_pending !== 8'd250) $display("FAIL ps_250 got %0d exp 250", bus.dbg_pending); else passed++;
    bus.hit_value_i = 4'd15;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.dbg_pending !== 8'd255) $display("FAIL ps_255_%0d got %0d exp 255", i, bus.dbg_pending); else passed++;
    end
    bus.hit_i = 1'b0;
    bus.hit_value_i = 4'd0;
    checks++; if (bus.dbg_working !== 12'h019) $display("FAIL ps_mid_working got %h exp 019", bus.dbg_working); else passed++;
    wait_idle(n);
    checks++; if (n !== 255) $display("FAIL ps_drain_cycles got %0d exp 255", n); else passed++;
    checks++; if (bus.dbg_working !== 12'h274) $display("FAIL ps_final got %h exp 274", bus.dbg_working); else passed++;
  endtask

  task automatic test_clear();
    publish();
    checks++; if (bus.score_o !== 12'h274) $display("FAIL clr_pre got %h exp 274", bus.score_o); else passed++;
    do_hit(4'd7);
    tick();
    tick();
    tick();
    checks++; if (bus.dbg_working !== 12'h276) $display("FAIL clr_mid got %h exp 276", bus.dbg_working); else passed++;
    bus.clear_i = 1'b1;
    bus.hit_i = 1'b1;
    bus.hit_value_i = 4'd4;
    tick();
    bus.clear_i = 1'b0;
    bus.hit_i = 1'b0;
    bus.hit_value_i = 4'd0;
    checks++; if (bus.score_o !== 12'h000) $display("FAIL clr_score got %h exp 000", bus.score_o); else passed++;
    checks++; if (bus.score_digit_o !== 2'b00) $display("FAIL clr_digit got %b exp 00", bus.score_digit_o); else passed++;
    checks++; if (bus.dbg_pending !== 8'd0) $display("FAIL clr_pending got %0d exp 0", bus.dbg_pending); else passed++;
    checks++; if (bus.busy_o !== 1'b0) $display("FAIL clr_busy got %b exp 0", bus.busy_o); else passed++;
    checks++; if (bus.dbg_inc !== 1'b0) $display("FAIL clr_state got %b exp 0", bus.dbg_inc); else passed++;
    tick();
    tick();
    tick();
    checks++; if (bus.dbg_working !== 12'h000) $display("FAIL clr_working got %h exp 000", bus.dbg_working); else passed++;
    publish();
    checks++; if (bus.score_o !== 12'h000) $display("FAIL clr_pub got %h exp 000", bus.score_o); else passed++;
    checks++; if (bus.score_digit_o !== 2'b00) $display("FAIL clr_pub_digit got %b exp 00", bus.score_digit_o); else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    do_hit(4'd5);
    tick();
    bus.hit_i = 1'b1;
    bus.hit_value_i = 4'd2;
    tick();
    bus.hit_value_i = 4'd3;
    tick();
    bus.hit_i = 1'b0;
    bus.hit_value_i = 4'd0;
    checks++; if (bus.dbg_pending !== 8'd8) $display("FAIL b2b_pending got %0d exp 8", bus.dbg_pending); else passed++;
    checks++; if (bus.dbg_working !== 12'h002) $display("FAIL b2b_mid got %h exp 002", bus.dbg_working); else passed++;
    wait_idle(n);
    checks++; if (n !== 8) $display("FAIL b2b_cycles got %0d exp 8", n); else passed++;
    checks++; if (bus.dbg_working !== 12'h010) $display("FAIL b2b_working got %h exp 010", bus.dbg_working); else passed++;
    publish();
    checks++; if (bus.score_o !== 12'h010) $display("FAIL b2b_pub got %h exp 010", bus.score_o); else passed++;
    checks++; if (bus.score_digit_o !== 2'b10) $display("FAIL b2b_digit got %b exp 10", bus.score_digit_o); else passed++;
  endtask

  task automatic test_vblk_inc();
    do_hit(4'd2);
    tick();
    bus.v_sync_i = 1'b0;
    tick();
    bus.v_sync_i = 1'b1;
    checks++; if (bus.score_o !== 12'h010) $display("FAIL vi_pre got %h exp 010", bus.score_o); else passed++;
    checks++; if (bus.dbg_working !== 12'h011) $display("FAIL vi_working got %h exp 011", bus.dbg_working); else passed++;
    tick();
    checks++; if (bus.score_o !== 12'h010) $display("FAIL vi_hold got %h exp 010", bus.score_o); else passed++;
    checks++; if (bus.busy_o !== 1'b0) $display("FAIL vi_busy got %b exp 0", bus.busy_o); else passed++;
    publish();
    checks++; if (bus.score_o !== 12'h012) $display("FAIL vi_next got %h exp 012", bus.score_o); else passed++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    bus.v_sync_i = 1'b1;
    bus.hit_i = 1'b0;
    bus.hit_value_i = 4'd0;
    bus.clear_i = 1'b0;
    test_reset();
    test_hit5();
    test_carry();
    test_sat();
    test_pend_sat();
    test_clear();
    test_back_to_back();
    test_vblk_inc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
